// File: rtl/cam_pkg.sv
// Shared types, register constants and sizing helpers for the OV2640 bring-up
// and SCCB write scheduler.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_PWDN     = 3'd0,
        ST_RSTHOLD  = 3'd1,
        ST_WAKE     = 3'd2,
        ST_FETCH    = 3'd3,
        ST_SEND     = 3'd4,
        ST_SRSTWAIT = 3'd5,
        ST_IDLE     = 3'd6,
        ST_HSEND    = 3'd7
    } cam_state_e;

    localparam logic [7:0] OV2640_WR_ID = 8'h60;
    localparam logic [7:0] COM7_ADDR    = 8'h12;
    localparam int         COM7_SRST    = 7;

    function automatic int cam_clog2(input int value);
        int w;
        w = 0;
        while ((32'sd1 <<< w) < value) begin
            w = w + 32'sd1;
        end
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

    function automatic int cam_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A COM7 write with the reset bit set restarts the sensor's register file.
    function automatic logic is_com7_srst(input logic [15:0] entry);
        return (entry[15:8] == COM7_ADDR) && entry[COM7_SRST];
    endfunction

endpackage

// File: rtl/sccb_scheduler.sv
// OV2640 power/reset sequencing, boot-table streaming and runtime register-write
// arbitration in front of the single SCCB sender.
module sccb_scheduler
    import cam_pkg::*;
#(
    parameter int PWDN_CYCLES    = 25000,
    parameter int RST_CYCLES     = 25000,
    parameter int WAKE_CYCLES    = 75000,
    parameter int SRST_CYCLES    = 25000,
    parameter int TBL_LEN        = 192,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    input  logic        host_req,
    input  logic [7:0]  host_addr,
    input  logic [7:0]  host_data,
    output logic        host_ack,
    output logic        sccb_req,
    output logic [15:0] sccb_data,
    input  logic        sccb_done,
    output logic        cam_pwdn,
    output logic        cam_reset,
    output logic        init_done,
    output logic        busy,
    output logic        err
);

    localparam int CNT_MAX = cam_max(cam_max(cam_max(PWDN_CYCLES, RST_CYCLES),
                                             cam_max(WAKE_CYCLES, SRST_CYCLES)),
                                     TIMEOUT_CYCLES);
    localparam int CNT_W   = cam_clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_PWDN    = CNT_W'(PWDN_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_RST     = CNT_W'(RST_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_WAKE    = CNT_W'(WAKE_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_SRST    = CNT_W'(SRST_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 32'sd1);
    // One cycle for the ROM address, one for the registered ROM data.
    localparam logic [CNT_W-1:0] CNT_FETCH   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [7:0]       TBL_END     = 8'(TBL_LEN);

    cam_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        tbl_addr_q;
    logic [7:0]        tbl_addr_d;
    logic [15:0]       sccb_data_q;
    logic              sccb_req_q;
    logic              host_ack_q;
    logic              cam_pwdn_q;
    logic              cam_reset_q;
    logic              init_done_q;
    logic              busy_q;
    logic              err_q;
    logic              cnt_zero_s;
    logic              xfer_end_s;
    logic              timeout_s;

    // Next boot-table index and completion/timeout of the write in flight.
    always_comb begin
        tbl_addr_d = tbl_addr_q + 8'd1;
        cnt_zero_s = (cnt_q == CNT_ZERO);
        xfer_end_s = sccb_req_q && (sccb_done || cnt_zero_s);
        timeout_s  = sccb_req_q && !sccb_done && cnt_zero_s;
    end

    // Sequencer FSM with the shared down-counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PWDN;
            cnt_q       <= CNT_PWDN;
            tbl_addr_q  <= 8'd0;
            sccb_data_q <= 16'd0;
            sccb_req_q  <= 1'b0;
            host_ack_q  <= 1'b0;
            cam_pwdn_q  <= 1'b1;
            cam_reset_q <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            host_ack_q <= 1'b0;
            case (state_q)
                ST_PWDN: begin
                    if (cnt_zero_s) begin
                        state_q    <= ST_RSTHOLD;
                        cnt_q      <= CNT_RST;
                        cam_pwdn_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_RSTHOLD: begin
                    if (cnt_zero_s) begin
                        state_q     <= ST_WAKE;
                        cnt_q       <= CNT_WAKE;
                        cam_reset_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_WAKE: begin
                    if (cnt_zero_s) begin
                        state_q <= ST_FETCH;
                        cnt_q   <= CNT_FETCH;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_FETCH: begin
                    if (cnt_zero_s) begin
                        state_q     <= ST_SEND;
                        cnt_q       <= CNT_TIMEOUT;
                        sccb_data_q <= tbl_data;
                        sccb_req_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_SEND: begin
                    if (xfer_end_s) begin
                        sccb_req_q <= 1'b0;
                        tbl_addr_q <= tbl_addr_d;
                        if (timeout_s) begin
                            err_q <= 1'b1;
                        end
                        if (is_com7_srst(sccb_data_q)) begin
                            state_q <= ST_SRSTWAIT;
                            cnt_q   <= CNT_SRST;
                        end else if (tbl_addr_d == TBL_END) begin
                            state_q     <= ST_IDLE;
                            init_done_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q <= ST_FETCH;
                            cnt_q   <= CNT_FETCH;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_SRSTWAIT: begin
                    if (!cnt_zero_s) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (tbl_addr_q == TBL_END) begin
                        state_q     <= ST_IDLE;
                        init_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        state_q <= ST_FETCH;
                        cnt_q   <= CNT_FETCH;
                    end
                end
                ST_IDLE: begin
                    // The request still visible during the ack pulse is the one just served.
                    if (host_req && !host_ack_q) begin
                        state_q     <= ST_HSEND;
                        cnt_q       <= CNT_TIMEOUT;
                        sccb_data_q <= {host_addr, host_data};
                        sccb_req_q  <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_HSEND: begin
                    if (xfer_end_s) begin
                        state_q    <= ST_IDLE;
                        sccb_req_q <= 1'b0;
                        host_ack_q <= 1'b1;
                        busy_q     <= 1'b0;
                        if (timeout_s) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q    <= ST_PWDN;
                    cnt_q      <= CNT_PWDN;
                    sccb_req_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
            endcase
        end
    end

    assign tbl_addr  = tbl_addr_q;
    assign host_ack  = host_ack_q;
    assign sccb_req  = sccb_req_q;
    assign sccb_data = sccb_data_q;
    assign cam_pwdn  = cam_pwdn_q;
    assign cam_reset = cam_reset_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sccb_scheduler.sv
// Directed bench for sccb_scheduler with shortened timing parameters and a
// three-entry boot table containing a COM7 soft-reset write.
module tb_sccb_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tbl_addr;
    logic [15:0] tbl_data = 16'h0000;
    logic        host_req;
    logic [7:0]  host_addr;
    logic [7:0]  host_data;
    logic        host_ack;
    logic        sccb_req;
    logic [15:0] sccb_data;
    logic        sccb_done;
    logic        cam_pwdn;
    logic        cam_reset;
    logic        init_done;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sccb_scheduler #(
        .PWDN_CYCLES   (4),
        .RST_CYCLES    (4),
        .WAKE_CYCLES   (8),
        .SRST_CYCLES   (6),
        .TBL_LEN       (3),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .host_req (host_req),
        .host_addr(host_addr),
        .host_data(host_data),
        .host_ack (host_ack),
        .sccb_req (sccb_req),
        .sccb_data(sccb_data),
        .sccb_done(sccb_done),
        .cam_pwdn (cam_pwdn),
        .cam_reset(cam_reset),
        .init_done(init_done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_f(input logic [7:0] a);
        case (a)
            8'd0:    return 16'h3A11;
            8'd1:    return 16'h1280;
            8'd2:    return 16'h5533;
            default: return 16'h0000;
        endcase
    endfunction

    // Synchronous boot ROM: data follows the address by one clock.
    always @(posedge clk) tbl_data <= rom_f(tbl_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse_done();
        sccb_done = 1'b1;
        tick();
        sccb_done = 1'b0;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_pwdn"},      32'(cam_pwdn),  32'd1);
        chk({p, "_camrst"},    32'(cam_reset), 32'd0);
        chk({p, "_req"},       32'(sccb_req),  32'd0);
        chk({p, "_data"},      32'(sccb_data), 32'd0);
        chk({p, "_addr"},      32'(tbl_addr),  32'd0);
        chk({p, "_ack"},       32'(host_ack),  32'd0);
        chk({p, "_init_done"}, 32'(init_done), 32'd0);
        chk({p, "_busy"},      32'(busy),      32'd1);
        chk({p, "_err"},       32'(err),       32'd0);
    endtask

    initial begin
        host_req  = 1'b0;
        host_addr = 8'h00;
        host_data = 8'h00;
        sccb_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;
        cyc = 0;

        // Run 1: power sequence, table walk with soft reset, host write.
        run_to(3);  chk("pwdn_hi_c3", 32'(cam_pwdn), 32'd1);
        run_to(4);  chk("pwdn_lo_c4", 32'(cam_pwdn), 32'd0);
                    chk("camrst_lo_c4", 32'(cam_reset), 32'd0);
        run_to(7);  chk("camrst_lo_c7", 32'(cam_reset), 32'd0);
        run_to(8);  chk("camrst_hi_c8", 32'(cam_reset), 32'd1);
        run_to(9);
        host_req  = 1'b1;
        host_addr = 8'h10;
        host_data = 8'h3C;
        run_to(17); chk("req_lo_c17", 32'(sccb_req), 32'd0);
                    chk("busy_wait", 32'(busy), 32'd1);
        run_to(18); chk("req_hi_c18", 32'(sccb_req), 32'd1);
                    chk("e0_data", 32'(sccb_data), 32'h3A11);
        run_to(27); chk("e0_req_held", 32'(sccb_req), 32'd1);
        pulse_done();
        chk("e0_req_drop", 32'(sccb_req), 32'd0);
        chk("no_ack_boot", 32'(host_ack), 32'd0);
        run_to(29); chk("e1_req_c29", 32'(sccb_req), 32'd0);
        run_to(30); chk("e1_req_c30", 32'(sccb_req), 32'd1);
                    chk("e1_data", 32'(sccb_data), 32'h1280);
        run_to(39);
        pulse_done();
        for (int c = 40; c < 48; c++) begin
            run_to(c);
            chk("srst_quiet", 32'(sccb_req), 32'd0);
        end
        run_to(48); chk("e2_req", 32'(sccb_req), 32'd1);
                    chk("e2_data", 32'(sccb_data), 32'h5533);
        run_to(57); chk("init_lo_c57", 32'(init_done), 32'd0);
        pulse_done();
        chk("init_hi_c58", 32'(init_done), 32'd1);
        chk("idle_req_c58", 32'(sccb_req), 32'd0);
        chk("idle_busy_c58", 32'(busy), 32'd0);
        run_to(59); chk("h_req", 32'(sccb_req), 32'd1);
                    chk("h_data", 32'(sccb_data), 32'h103C);
                    chk("h_busy", 32'(busy), 32'd1);
                    chk("h_ack_early", 32'(host_ack), 32'd0);
        run_to(62);
        pulse_done();
        chk("h_ack_c63", 32'(host_ack), 32'd1);
        chk("h_req_drop", 32'(sccb_req), 32'd0);
        chk("h_err", 32'(err), 32'd0);
        run_to(64); chk("h_ack_single", 32'(host_ack), 32'd0);
                    chk("h_no_reaccept", 32'(sccb_req), 32'd0);
        host_req = 1'b0;
        run_to(65); chk("idle_req_c65", 32'(sccb_req), 32'd0);
                    chk("idle_busy_c65", 32'(busy), 32'd0);
        pulse_done();
        chk("stray_done_err", 32'(err), 32'd0);
        chk("stray_done_ack", 32'(host_ack), 32'd0);
        host_req  = 1'b1;
        host_addr = 8'h04;
        host_data = 8'hA5;
        run_to(67); chk("h2_req", 32'(sccb_req), 32'd1);
                    chk("h2_data", 32'(sccb_data), 32'h04A5);
        run_to(69);
        rst = 1'b1;
        #1;
        chk_reset("mid_h");
        host_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;

        // Run 2: coincident done/expiry, then a real timeout on the soft-reset entry.
        run_to(4);  chk("r2_pwdn_lo", 32'(cam_pwdn), 32'd0);
        run_to(18); chk("r2_req", 32'(sccb_req), 32'd1);
                    chk("r2_e0_data", 32'(sccb_data), 32'h3A11);
        run_to(37);
        pulse_done();
        chk("coinc_req", 32'(sccb_req), 32'd0);
        chk("coinc_err", 32'(err), 32'd0);
        run_to(40); chk("to_req", 32'(sccb_req), 32'd1);
                    chk("to_data", 32'(sccb_data), 32'h1280);
        run_to(59); chk("to_req_c59", 32'(sccb_req), 32'd1);
                    chk("to_err_c59", 32'(err), 32'd0);
        run_to(60); chk("to_req_c60", 32'(sccb_req), 32'd0);
                    chk("to_err_c60", 32'(err), 32'd1);
        run_to(67); chk("to_next_c67", 32'(sccb_req), 32'd0);
        run_to(68); chk("to_next_req", 32'(sccb_req), 32'd1);
                    chk("to_next_data", 32'(sccb_data), 32'h5533);
                    chk("err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset("mid_t");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;

        // Run 3: restart from power-down after a mid-send reset.
        run_to(4);  chk("r3_pwdn_lo", 32'(cam_pwdn), 32'd0);
        run_to(8);  chk("r3_camrst_hi", 32'(cam_reset), 32'd1);
        run_to(18); chk("r3_req", 32'(sccb_req), 32'd1);
                    chk("r3_data", 32'(sccb_data), 32'h3A11);
                    chk("r3_addr", 32'(tbl_addr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
